// File: rtl/mem_master.sv
// Single-outstanding memory command master: IDLE -> ACCESS -> DONE handshake between a client and a memory.
// Optional ACCESS timeout is built when MEM_MASTER_TIMEOUT_EN is defined.
module mem_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_wr,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  mem_sel,
   output logic                  mem_wr_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]            state;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  rsp_wr_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  accept;
   logic                  timeout;

   assign accept = (state == IDLE) && cmd_valid;

`ifdef MEM_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             rsp_err_q;

   // Fires on the TIMEOUT_CYCLES-th consecutive stalled edge; leaving ACCESS means the counter never wraps.
   assign timeout = (state == ACCESS) && !mem_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (accept)
            wait_cnt <= '0;
         else if ((state == ACCESS) && !mem_ready && !timeout)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == ACCESS && (mem_ready || timeout))
            rsp_err_q <= !mem_ready;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rsp_wr_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state)
            IDLE:    if (cmd_valid) state <= ACCESS;
            ACCESS: begin
               if (mem_ready || timeout) begin
                  state       <= DONE;
                  rsp_wr_q    <= wr_q;
                  rsp_rdata_q <= (mem_ready && !wr_q) ? mem_rdata : '0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Command capture; these never reach an output outside ACCESS, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= cmd_wr;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
      end
   end

   assign cmd_ready = (state == IDLE) && !reset;
   assign busy      = (state != IDLE);
   assign mem_sel   = (state == ACCESS);
   assign mem_wr_rd = mem_sel && wr_q;
   assign mem_addr  = mem_sel ? addr_q : '0;
   assign mem_wdata = (mem_sel && wr_q) ? wdata_q : '0;
   assign rsp_valid = (state == DONE);
   assign rsp_wr    = rsp_wr_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: transaction-level reference model plus a memory responder, directed and random stimulus.
// Timeout expectations follow MEM_MASTER_TIMEOUT_EN as compiled.
module tb_mem_master;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset, cmd_valid, cmd_wr, mem_ready;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata, mem_rdata;
   logic          cmd_ready, rsp_valid, rsp_wr, rsp_err, busy, mem_sel, mem_wr_rd;
   logic [DW-1:0] rsp_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .mem_sel(mem_sel), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int sel_cnt = 0;
   int vld_cnt = 0;

   // Reference: the one command in flight, the response owed this cycle, and the held response fields.
   logic [DW-1:0] mem [256];
   bit            m_act, m_wr, m_pulse, m_rsp_wr, m_rsp_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rsp_rdata;
   int            m_wait;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_rsp(input bit err);
      m_act       = 1'b0;
      m_pulse     = 1'b1;
      m_rsp_wr    = m_wr;
      m_rsp_err   = err;
      m_rsp_rdata = (err || m_wr) ? '0 : mem[m_addr];
      if (!err && m_wr) mem[m_addr] = m_wdata;
   endtask

   task automatic model_edge();
      if (reset) begin
         m_act = 1'b0; m_pulse = 1'b0;
         m_rsp_wr = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = '0;
      end else if (m_pulse) begin
         m_pulse = 1'b0;
      end else if (m_act) begin
         if (mem_ready) finish_rsp(1'b0);
         else begin
            m_wait++;
`ifdef MEM_MASTER_TIMEOUT_EN
            if (m_wait == TMO) finish_rsp(1'b1);
`endif
         end
      end else if (cmd_valid) begin
         m_act = 1'b1; m_wr = cmd_wr; m_addr = cmd_addr; m_wdata = cmd_wdata; m_wait = 0;
      end
   endtask

   // Called at a falling edge with inputs set; checks outputs, then advances one clock.
   task automatic step();
      mem_rdata = (m_act && !m_wr) ? mem[m_addr] : DW'($urandom);
      #1;
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_act && !m_pulse && !reset));
      chk("busy",      32'(busy),      32'(m_act || m_pulse));
      chk("mem_sel",   32'(mem_sel),   32'(m_act));
      chk("mem_wr_rd", 32'(mem_wr_rd), 32'(m_act && m_wr));
      chk("mem_addr",  32'(mem_addr),  m_act ? 32'(m_addr) : 32'd0);
      chk("mem_wdata", 32'(mem_wdata), (m_act && m_wr) ? 32'(m_wdata) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_pulse));
      chk("rsp_wr",    32'(rsp_wr),    32'(m_rsp_wr));
      chk("rsp_err",   32'(rsp_err),   32'(m_rsp_err));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_rdata));
      sel_cnt += int'(mem_sel === 1'b1);
      vld_cnt += int'(rsp_valid === 1'b1);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      int gap;
      for (int i = 0; i < 256; i++) mem[i] = 16'h5678;
      reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      @(posedge clk); model_edge(); @(negedge clk);
      step();
      reset = 1'b0; #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_mem_sel",   32'(mem_sel),   32'd0);

      // Write 2 <- 3524, ready two cycles after mem_sel rises.
      sel_cnt = 0; vld_cnt = 0;
      cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'd2; cmd_wdata = 16'h3524; step();
      cmd_valid = 0; step(); step();
      mem_ready = 1; step();
      chk("w2_rsp_wr", 32'(rsp_wr), 32'd1);
      mem_ready = 1; step();
      mem_ready = 1; step();
      mem_ready = 0;
      chk("w2_sel_cycles", 32'(sel_cnt), 32'd3);
      chk("w2_rsp_count",  32'(vld_cnt), 32'd1);
      chk("w2_rsp_rdata",  32'(rsp_rdata), 32'd0);
      chk("w2_rsp_err",    32'(rsp_err), 32'd0);

      // Read 7 with ready on the first ACCESS cycle.
      cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'd7; step();
      cmd_valid = 0; mem_ready = 1; step();
      chk("r7_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("r7_rsp_rdata", 32'(rsp_rdata), 32'h5678);
      mem_ready = 0; step(); step();
      chk("r7_rdata_held", 32'(rsp_rdata), 32'h5678);

      // cmd_valid held: write 3 <- BEEF then read 3.
      mem_ready = 1; cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'd3; cmd_wdata = 16'hBEEF; step();
      cmd_wr = 0; step();
      gap = 0;
      for (int i = 0; i < 6 && mem_sel !== 1'b1; i++) begin gap++; step(); end
      chk("b2b_gap_ge1", 32'(gap >= 1), 32'd1);
      cmd_valid = 0; step();
      chk("b2b_read_val", 32'(rsp_rdata), 32'hBEEF);
      step(); mem_ready = 0;

      // Stalled memory.
      sel_cnt = 0;
      cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'd3; step(); cmd_valid = 0;
`ifdef MEM_MASTER_TIMEOUT_EN
      for (int i = 0; i < 12; i++) step();
      chk("tmo_sel_cycles", 32'(sel_cnt), 32'(TMO));
      chk("tmo_rsp_err",    32'(rsp_err), 32'd1);
      chk("tmo_rsp_rdata",  32'(rsp_rdata), 32'd0);
`else
      for (int i = 0; i < 100; i++) step();
      chk("stall_sel_high", 32'(mem_sel), 32'd1);
      mem_ready = 1; step(); mem_ready = 0; step(); step();
`endif

      // Reset during the second ACCESS cycle of a read.
      vld_cnt = 0;
      cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'd9; step(); cmd_valid = 0;
      step();
      reset = 1; step();
      chk("rst_mem_sel",  32'(mem_sel), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 0; #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      mem_ready = 1; step(); step(); mem_ready = 0;
      chk("rst_no_rsp", 32'(vld_cnt), 32'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(199) == 0);
         cmd_valid = $urandom_range(1);
         cmd_wr    = $urandom_range(1);
         cmd_addr  = AW'($urandom_range(15));
         cmd_wdata = DW'($urandom);
         mem_ready = ($urandom_range(9) < 4);
         step();
      end
      reset = 0; cmd_valid = 0; mem_ready = 1;
      step(); step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
